// File: rtl/tt_um_programmable_timer.sv
// 8-bit programmable down-counting timer tile: loads a reload value, counts to zero,
// pulses terminal count, then stops (one-shot) or reloads (auto-reload).
//
// state  | meaning
// S_IDLE | loaded or reset, waiting for a START rising edge
// S_RUN  | counting down one step per prescaler tick
// S_DONE | one-shot expiry reached, count parked at 0
module tt_um_programmable_timer #(
   parameter int PRESCALE = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [7:0] PS_LAST = 8'(PRESCALE - 1);

   state_t     state_q, state_d;
   logic [7:0] count_q, count_d;
   logic [7:0] reload_q, reload_d;
   logic [7:0] presc_q, presc_d;
   logic       tc_q, tc_d;
   logic       start_q, start_d;

   logic start_i, load_i, auto_i, pause_i, view_i;
   logic start_edge, tick;
   logic unused_ui;

   assign start_i   = ui_in[0];
   assign load_i    = ui_in[1];
   assign auto_i    = ui_in[2];
   assign pause_i   = ui_in[3];
   assign view_i    = ui_in[7];
   assign unused_ui = &{1'b0, ui_in[6:4]};

   assign start_edge = start_i & ~start_q;
   assign tick       = (state_q == S_RUN) && !pause_i && (presc_q == PS_LAST);

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      presc_d  = presc_q;
      tc_d     = 1'b0;
      start_d  = start_i;
      if (load_i) begin
         reload_d = uio_in;
         count_d  = uio_in;
         state_d  = S_IDLE;
         presc_d  = 8'd0;
      end else if (start_edge && state_q != S_RUN) begin
         count_d = reload_q;
         presc_d = 8'd0;
         if (reload_q != 8'd0) begin
            state_d = S_RUN;
         end else begin
            state_d = S_DONE;
            tc_d    = 1'b1;
         end
      end else if (state_q == S_RUN && !pause_i) begin
         // A start edge while running is ignored; counting carries on.
         if (tick) begin
            presc_d = 8'd0;
            if (count_q > 8'd1) begin
               count_d = count_q - 8'd1;
            end else begin
               tc_d = 1'b1;
               if (auto_i) begin
                  count_d = reload_q;
               end else begin
                  count_d = 8'd0;
                  state_d = S_DONE;
               end
            end
         end else begin
            presc_d = presc_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         count_q  <= 8'd0;
         reload_q <= 8'd0;
         presc_q  <= 8'd0;
         tc_q     <= 1'b0;
         start_q  <= 1'b0;
      end else if (ena) begin
         state_q  <= state_d;
         count_q  <= count_d;
         reload_q <= reload_d;
         presc_q  <= presc_d;
         tc_q     <= tc_d;
         start_q  <= start_d;
      end
   end

   assign uo_out  = view_i ? {5'b0, state_q == S_RUN, state_q == S_DONE, tc_q} : count_q;
   assign uio_out = 8'h00;
   assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_programmable_timer.sv
// Bench for the programmable timer: directed vector table, hand-written corner
// sequences, then random stimulus against a behavioural model, for PRESCALE 1 and 4.
module tb_tt_um_programmable_timer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b1;
   logic [7:0] ui_in = 8'h00;
   logic [7:0] uio_in = 8'h00;
   logic [7:0] uo1, uio_out1, uio_oe1;
   logic [7:0] uo4, uio_out4, uio_oe4;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   tt_um_programmable_timer #(.PRESCALE(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
      .uo_out(uo1), .uio_out(uio_out1), .uio_oe(uio_oe1));

   tt_um_programmable_timer #(.PRESCALE(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
      .uo_out(uo4), .uio_out(uio_out4), .uio_oe(uio_oe4));

   typedef struct {
      logic [7:0] ui;
      logic [7:0] din;
      logic [7:0] exp;
   } vec_t;

   // Model phases: 0 idle, 1 counting, 2 finished
   typedef struct {
      int   ph;
      int   cnt;
      int   rel;
      int   elapsed;
      bit   tc;
      bit   prev_start;
   } mdl_t;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %02h expected %02h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic mdl_t mreset();
      mdl_t m;
      m.ph = 0; m.cnt = 0; m.rel = 0; m.elapsed = 0; m.tc = 0; m.prev_start = 0;
      return m;
   endfunction

   // One enabled clock of the timer described in words: load wins, then a fresh
   // start arms (or finishes immediately for zero), else running time accumulates
   // and every ps-th unpaused cycle consumes one count.
   function automatic mdl_t mstep(mdl_t m, logic [7:0] ui, logic [7:0] din, bit en, int ps);
      mdl_t n;
      if (!en) return m;
      n = m;
      n.prev_start = ui[0];
      n.tc = 0;
      if (ui[1]) begin
         n.rel = int'(din); n.cnt = int'(din); n.ph = 0; n.elapsed = 0;
      end else if (ui[0] && !m.prev_start && m.ph != 1) begin
         n.cnt = m.rel; n.elapsed = 0;
         if (m.rel == 0) begin n.ph = 2; n.tc = 1; end
         else n.ph = 1;
      end else if (m.ph == 1 && !ui[3]) begin
         n.elapsed = (m.elapsed + 1) % ps;
         if (n.elapsed == 0) begin
            if (m.cnt > 1) n.cnt = m.cnt - 1;
            else begin
               n.tc = 1;
               if (ui[2]) n.cnt = m.rel;
               else begin n.cnt = 0; n.ph = 2; end
            end
         end
      end
      return n;
   endfunction

   function automatic logic [7:0] mout(mdl_t m, logic view);
      if (view) return {5'b0, m.ph == 1, m.ph == 2, m.tc};
      return m.cnt[7:0];
   endfunction

   vec_t tbl[$];
   mdl_t m1, m4;

   initial begin
      // Test 1: one-shot from 5
      tbl.push_back('{8'h02, 8'd5, 8'd5});
      tbl.push_back('{8'h01, 8'd0, 8'd5});
      tbl.push_back('{8'h01, 8'd0, 8'd4});
      tbl.push_back('{8'h01, 8'd0, 8'd3});
      tbl.push_back('{8'h01, 8'd0, 8'd2});
      tbl.push_back('{8'h01, 8'd0, 8'd1});
      tbl.push_back('{8'h81, 8'd0, 8'h03});
      tbl.push_back('{8'h81, 8'd0, 8'h02});
      tbl.push_back('{8'h01, 8'd0, 8'd0});
      tbl.push_back('{8'h00, 8'd0, 8'd0});
      // Test 2: auto-reload from 3
      tbl.push_back('{8'h06, 8'd3, 8'd3});
      tbl.push_back('{8'h05, 8'd0, 8'd3});
      tbl.push_back('{8'h04, 8'd0, 8'd2});
      tbl.push_back('{8'h04, 8'd0, 8'd1});
      tbl.push_back('{8'h84, 8'd0, 8'h05});
      tbl.push_back('{8'h04, 8'd0, 8'd2});
      tbl.push_back('{8'h84, 8'd0, 8'h04});
      tbl.push_back('{8'h84, 8'd0, 8'h05});
      tbl.push_back('{8'h04, 8'd0, 8'd2});
      // Test 4: zero reload finishes at once
      tbl.push_back('{8'h02, 8'd0, 8'd0});
      tbl.push_back('{8'h81, 8'd0, 8'h03});
      tbl.push_back('{8'h81, 8'd0, 8'h02});
      tbl.push_back('{8'h80, 8'd0, 8'h02});
      // Test 3: pause at 7
      tbl.push_back('{8'h02, 8'd10, 8'd10});
      tbl.push_back('{8'h01, 8'd0, 8'd10});
      tbl.push_back('{8'h00, 8'd0, 8'd9});
      tbl.push_back('{8'h00, 8'd0, 8'd8});
      tbl.push_back('{8'h00, 8'd0, 8'd7});
      tbl.push_back('{8'h08, 8'd0, 8'd7});
      tbl.push_back('{8'h08, 8'd0, 8'd7});
      tbl.push_back('{8'h08, 8'd0, 8'd7});
      tbl.push_back('{8'h08, 8'd0, 8'd7});
      tbl.push_back('{8'h00, 8'd0, 8'd6});
      tbl.push_back('{8'h00, 8'd0, 8'd5});
      // Test 5: load mid-run at 4
      tbl.push_back('{8'h00, 8'd0, 8'd4});
      tbl.push_back('{8'h02, 8'h20, 8'h20});
      tbl.push_back('{8'h80, 8'd0, 8'h00});

      #12;
      chk("reset_count", uo1, 8'h00);
      ui_in = 8'h80;
      #1;
      chk("reset_status", uo1, 8'h00);
      chk("uio_out", uio_out1, 8'h00);
      chk("uio_oe", uio_oe1, 8'h00);
      ui_in = 8'h00;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      foreach (tbl[i]) begin
         ui_in = tbl[i].ui;
         uio_in = tbl[i].din;
         cyc();
         chk($sformatf("vec%0d", i), uo1, tbl[i].exp);
      end

      // Async reset mid-run
      ui_in = 8'h02; uio_in = 8'd9; cyc();
      ui_in = 8'h01; cyc();
      ui_in = 8'h00; cyc();
      chk("pre_rst_count", uo1, 8'd8);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_count", uo1, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      ui_in = 8'h80;
      cyc();
      chk("idle_after_rst", uo1, 8'h00);

      // Prescale 4: count changes every 4 cycles, tc 8 cycles after arming
      ui_in = 8'h02; uio_in = 8'd2; cyc();
      ui_in = 8'h01; cyc();
      chk("ps4_arm", uo4, 8'd2);
      ui_in = 8'h00;
      for (int k = 1; k < 8; k++) begin
         cyc();
         chk($sformatf("ps4_k%0d", k), uo4, (k < 4) ? 8'd2 : 8'd1);
      end
      ui_in = 8'h80;
      cyc();
      chk("ps4_tc", uo4, 8'h03);
      cyc();
      chk("ps4_done", uo4, 8'h02);

      // ena=0 freezes everything, including the start edge detector
      ui_in = 8'h02; uio_in = 8'd20; cyc();
      ui_in = 8'h01; cyc();
      ui_in = 8'h00; cyc();
      chk("ena_pre", uo1, 8'd19);
      ena = 1'b0;
      for (int k = 0; k < 5; k++) begin
         ui_in = {7'b0, k[0]};
         cyc();
         chk($sformatf("ena_hold%0d", k), uo1, 8'd19);
      end
      ena = 1'b1;
      ui_in = 8'h00;
      cyc();
      chk("ena_resume", uo1, 8'd18);

      // Random stimulus against the model
      @(negedge clk);
      rst_n = 1'b0;
      #1 rst_n = 1'b1;
      m1 = mreset();
      m4 = mreset();
      for (int c = 0; c < 3000; c++) begin
         logic [7:0] ui;
         ui = 8'h00;
         ui[0] = ($urandom_range(0, 3) == 0);
         ui[1] = ($urandom_range(0, 23) == 0);
         ui[2] = $urandom_range(0, 1);
         ui[3] = ($urandom_range(0, 7) == 0);
         ui[7] = $urandom_range(0, 1);
         ui[6:4] = 3'($urandom_range(0, 7));
         ui_in = ui;
         uio_in = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
         ena = ($urandom_range(0, 7) != 0);
         @(posedge clk);
         m1 = mstep(m1, ui_in, uio_in, ena, 1);
         m4 = mstep(m4, ui_in, uio_in, ena, 4);
         #1;
         chk("rand_ps1", uo1, mout(m1, ui_in[7]));
         chk("rand_ps4", uo4, mout(m4, ui_in[7]));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
